// File: rtl/multiword_adder_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multiword_adder_sequencer (and its ripple_carry_adder slice)
// Description : Performs a WIDTH*WORDS-bit addition by running one WIDTH-bit
//               ripple_carry_adder over the operand words, least-significant
//               word first, with the word carry kept in a register.
//               Handshake: start is accepted in IDLE (ready=1), busy is high
//               for WORDS cycles, then done pulses for one cycle.
// Ports       : clk, reset (sync, active-high), start, op_a, op_b, carry_in,
//               [sub], ready, busy, done, result, carry_out, overflow.
// Option      : define MULTIWORD_ADDER_SUB_EN to add the 'sub' input, which
//               turns the operation into op_a - op_b.
// Revision    : 1.0 - initial release
// ============================================================================

module ripple_carry_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] final_sum,
    output logic             carry_out
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = carry_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign final_sum[i] = input_a[i] ^ input_b[i] ^ w_c[i];
        assign w_c[i+1]     = (input_a[i] & input_b[i]) |
                              (w_c[i] & (input_a[i] ^ input_b[i]));
    end

    assign carry_out = w_c[WIDTH];

endmodule

module multiword_adder_sequencer #(
    parameter int WIDTH = 32,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH*WORDS-1:0] op_a,
    input  logic [WIDTH*WORDS-1:0] op_b,
    input  logic                   carry_in,
`ifdef MULTIWORD_ADDER_SUB_EN
    input  logic                   sub,
`endif
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] result,
    output logic                   carry_out,
    output logic                   overflow
);

    localparam int                 c_idx_w    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(WORDS - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_idx_w-1:0]     r_idx;
    logic                   r_carry;
    logic [WIDTH*WORDS-1:0] r_op_a;
    logic [WIDTH*WORDS-1:0] r_op_b;
    logic [WIDTH*WORDS-1:0] r_result;
    logic                   r_carry_out;
    logic                   r_overflow;

    logic [31:0]            w_base;
    logic [WIDTH-1:0]       w_a_word;
    logic [WIDTH-1:0]       w_b_word;
    logic [WIDTH-1:0]       w_sum;
    logic                   w_cout;
    logic                   w_msb_cin;
    logic [WIDTH*WORDS-1:0] w_b_capt;
    logic                   w_c0;
    logic                   w_last;

    // Operand B and the word-0 carry are conditioned at capture time so the
    // datapath itself is identical for add and subtract.
`ifdef MULTIWORD_ADDER_SUB_EN
    assign w_b_capt = sub ? ~op_b : op_b;
    assign w_c0     = sub ? 1'b1 : carry_in;
`else
    assign w_b_capt = op_b;
    assign w_c0     = carry_in;
`endif

    assign w_base   = 32'(r_idx) * 32'(WIDTH);
    assign w_a_word = r_op_a[w_base +: WIDTH];
    assign w_b_word = r_op_b[w_base +: WIDTH];
    assign w_last   = (r_idx == c_last_idx);

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .input_a   (w_a_word),
        .input_b   (w_b_word),
        .carry_in  (r_carry),
        .final_sum (w_sum),
        .carry_out (w_cout)
    );

    // The carry into the slice MSB is not a port of the adder; it is
    // recovered from the MSB sum equation instead.
    assign w_msb_cin = w_a_word[WIDTH-1] ^ w_b_word[WIDTH-1] ^ w_sum[WIDTH-1];

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_run;
            c_st_run:  if (w_last) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_op_a   <= op_a;
                        r_op_b   <= w_b_capt;
                        r_carry  <= w_c0;
                        r_idx    <= '0;
                        r_result <= '0;
                    end
                end
                c_st_run: begin
                    r_result[w_base +: WIDTH] <= w_sum;
                    r_carry                   <= w_cout;
                    if (w_last) begin
                        r_carry_out <= w_cout;
                        r_overflow  <= w_cout ^ w_msb_cin;
                        r_idx       <= '0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready     = (r_state == c_st_idle);
    assign busy      = (r_state == c_st_run);
    assign done      = (r_state == c_st_done);
    assign result    = r_result;
    assign carry_out = r_carry_out;
    assign overflow  = r_overflow;

endmodule

`default_nettype wire
